// File: rtl/glip_stress_engine.sv
// GLIP FIFO I/O stress engine: host-driven write (checked), read (generated) and
// loopback tests over an LFSR data stream, with optional random wait injection.
module glip_stress_engine #(
  parameter int unsigned WIDTH        = 16,
  parameter logic [63:0] POLY         = 64'hB400,
  parameter int unsigned COUNT_LSHIFT = 10,
  parameter int unsigned DELAY_W      = 12
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fifo_out_valid,
  input  logic             fifo_out_ready,
  output logic [WIDTH-1:0] fifo_out_data,
  input  logic             fifo_in_valid,
  output logic             fifo_in_ready,
  input  logic [WIDTH-1:0] fifo_in_data,
  input  logic             stall_flag,
  input  logic             error_flag,
  output logic [15:0]      err_count,
  output logic             error,
  output logic             idle
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SEED     = 3'd1;
  localparam logic [2:0] S_COUNT    = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_STATUS   = 3'd4;
  localparam logic [2:0] S_HOSTSTAT = 3'd5;

  localparam logic [1:0] M_WRITE = 2'd0;
  localparam logic [1:0] M_READ  = 2'd1;

  logic [2:0]         state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic               rnd_en_q, rnd_en_d;
  logic [WIDTH-1:0]   lfsr_q, lfsr_d;
  logic [31:0]        words_left_q, words_left_d;
  logic [31:0]        word_idx_q, word_idx_d;
  logic [31:0]        first_idx_q, first_idx_d;
  logic [15:0]        err_count_q, err_count_d;
  logic               error_q, error_d;
  logic [1:0]         stat_idx_q, stat_idx_d;
  logic [WIDTH-1:0]   buf_q, buf_d;
  logic               buf_valid_q, buf_valid_d;
  logic               int_stall_q, int_stall_d;
  logic               rnd_phase_q, rnd_phase_d;
  logic [DELAY_W-1:0] dly_cnt_q, dly_cnt_d;

  logic [WIDTH-1:0] lfsr_step;
  logic [WIDTH-1:0] stat_word;
  logic [31:0]      cnt_load;
  logic [2:0]       end_state;
  logic             in_ready, out_valid, in_fire, out_fire, count_fire;
  logic [WIDTH-1:0] out_data;

  // The word under test is always one step ahead of the stored LFSR state.
  assign lfsr_step = {lfsr_q[WIDTH-2:0], ^(lfsr_q & POLY[WIDTH-1:0])};
  assign cnt_load  = {16'b0, fifo_in_data[15:0]} << COUNT_LSHIFT;
  assign end_state = (mode_q == M_READ) ? S_HOSTSTAT : S_STATUS;

  always_comb begin
    case (stat_idx_q)
      2'd0:    stat_word = (err_count_q == 16'd0) ? WIDTH'(16'hCAFE) : WIDTH'(16'hDEAD);
      2'd1:    stat_word = WIDTH'(err_count_q);
      default: stat_word = WIDTH'(first_idx_q);
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    case (state_q)
      S_IDLE:                      in_ready = !error_q;
      S_SEED, S_COUNT, S_HOSTSTAT: in_ready = 1'b1;
      S_RUN: begin
        if (mode_q == M_WRITE) begin
          in_ready = !int_stall_q;
        end else if (mode_q == M_READ) begin
          in_ready  = 1'b1;
          out_valid = !int_stall_q;
          out_data  = lfsr_step;
        end else begin
          // Refill a draining buffer only if another word is still owed.
          out_valid = buf_valid_q && !int_stall_q;
          out_data  = buf_q;
          in_ready  = !int_stall_q &&
                      (!buf_valid_q || (fifo_out_ready && words_left_q > 32'd1));
        end
      end
      S_STATUS: begin
        out_valid = 1'b1;
        out_data  = stat_word;
      end
      default: ;
    endcase
  end

  assign in_fire    = fifo_in_valid && in_ready;
  assign out_fire   = out_valid && fifo_out_ready;
  assign count_fire = (state_q == S_RUN) && ((mode_q == M_WRITE) ? in_fire : out_fire);

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    rnd_en_d     = rnd_en_q;
    lfsr_d       = lfsr_q;
    words_left_d = words_left_q;
    word_idx_d   = word_idx_q;
    first_idx_d  = first_idx_q;
    err_count_d  = err_count_q;
    error_d      = error_q;
    stat_idx_d   = stat_idx_q;
    buf_d        = buf_q;
    buf_valid_d  = buf_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          if (fifo_in_data[15:8] == 8'h5A && fifo_in_data[1:0] != 2'd3) begin
            mode_d   = fifo_in_data[1:0];
            rnd_en_d = fifo_in_data[4];
            state_d  = S_SEED;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_SEED: begin
        if (in_fire) begin
          lfsr_d  = (fifo_in_data == '0) ? WIDTH'(1) : fifo_in_data;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (in_fire) begin
          words_left_d = cnt_load;
          word_idx_d   = 32'd0;
          err_count_d  = 16'd0;
          first_idx_d  = 32'd0;
          stat_idx_d   = 2'd0;
          buf_valid_d  = 1'b0;
          state_d      = (cnt_load == 32'd0) ? end_state : S_RUN;
        end
      end
      S_RUN: begin
        if (count_fire) begin
          words_left_d = words_left_q - 32'd1;
          word_idx_d   = word_idx_q + 32'd1;
          if (!error_flag) lfsr_d = lfsr_step;
          if (words_left_q == 32'd1) state_d = end_state;
        end
        if (mode_q == M_WRITE) begin
          if (in_fire && fifo_in_data != lfsr_step) begin
            error_d = 1'b1;
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            if (err_count_q == 16'd0) first_idx_d = word_idx_q;
          end
        end else if (mode_q == M_READ) begin
          if (in_fire && fifo_in_data[15:0] == 16'hDEAD) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          if (out_fire) buf_valid_d = 1'b0;
          if (in_fire) begin
            buf_d       = fifo_in_data;
            buf_valid_d = 1'b1;
          end
        end
      end
      S_STATUS: begin
        if (out_fire) begin
          stat_idx_d = stat_idx_q + 2'd1;
          if (stat_idx_q == 2'd2) state_d = S_IDLE;
        end
      end
      S_HOSTSTAT: begin
        if (in_fire) begin
          if (fifo_in_data[15:0] != 16'hCAFE) error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    int_stall_d = stall_flag | rnd_phase_q;
    rnd_phase_d = 1'b0;
    dly_cnt_d   = '0;
    if (state_q == S_RUN && rnd_en_q) begin
      rnd_phase_d = rnd_phase_q;
      if (dly_cnt_q == '0) begin
        rnd_phase_d = !rnd_phase_q;
        dly_cnt_d   = (lfsr_q[DELAY_W-1:0] == '0) ? '1 : lfsr_q[DELAY_W-1:0];
      end else begin
        dly_cnt_d = dly_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      mode_q       <= M_WRITE;
      rnd_en_q     <= 1'b0;
      lfsr_q       <= WIDTH'(1);
      words_left_q <= 32'd0;
      word_idx_q   <= 32'd0;
      first_idx_q  <= 32'd0;
      err_count_q  <= 16'd0;
      error_q      <= 1'b0;
      stat_idx_q   <= 2'd0;
      buf_q        <= '0;
      buf_valid_q  <= 1'b0;
      int_stall_q  <= 1'b0;
      rnd_phase_q  <= 1'b0;
      dly_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      rnd_en_q     <= rnd_en_d;
      lfsr_q       <= lfsr_d;
      words_left_q <= words_left_d;
      word_idx_q   <= word_idx_d;
      first_idx_q  <= first_idx_d;
      err_count_q  <= err_count_d;
      error_q      <= error_d;
      stat_idx_q   <= stat_idx_d;
      buf_q        <= buf_d;
      buf_valid_q  <= buf_valid_d;
      int_stall_q  <= int_stall_d;
      rnd_phase_q  <= rnd_phase_d;
      dly_cnt_q    <= dly_cnt_d;
    end
  end

  assign fifo_out_valid = out_valid;
  assign fifo_out_data  = out_data;
  assign fifo_in_ready  = in_ready;
  assign err_count      = err_count_q;
  assign error          = error_q;
  assign idle           = (state_q == S_IDLE);

endmodule

// File: tb/tb_glip_stress_engine.sv
// Directed bench for glip_stress_engine: write/read/loopback tests, random waits and
// boundary cases, with an independent LFSR model producing every expected word.
module tb_glip_stress_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_out_valid;
  logic        fifo_out_ready = 1'b0;
  logic [31:0] fifo_out_data;
  logic        fifo_in_valid = 1'b0;
  logic        fifo_in_ready;
  logic [31:0] fifo_in_data = '0;
  logic        stall_flag = 1'b0;
  logic        error_flag = 1'b0;
  logic [15:0] err_count;
  logic        error;
  logic        idle;

  int n_checks = 0;
  int n_pass   = 0;

  glip_stress_engine #(
    .WIDTH        (32),
    .POLY         (64'hB400),
    .COUNT_LSHIFT (4),
    .DELAY_W      (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_out_valid (fifo_out_valid),
    .fifo_out_ready (fifo_out_ready),
    .fifo_out_data  (fifo_out_data),
    .fifo_in_valid  (fifo_in_valid),
    .fifo_in_ready  (fifo_in_ready),
    .fifo_in_data   (fifo_in_data),
    .stall_flag     (stall_flag),
    .error_flag     (error_flag),
    .err_count      (err_count),
    .error          (error),
    .idle           (idle)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return {x[30:0], ^(x & 32'h0000B400)};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // One cycle: drive inputs just after the falling edge, then let combinational outputs settle.
  task automatic drive(input bit iv, input logic [31:0] id, input bit ordy, input bit st);
    @(negedge clk);
    fifo_in_valid  = iv;
    fifo_in_data   = id;
    fifo_out_ready = ordy;
    stall_flag     = st;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    fifo_in_valid = 1'b0; fifo_out_ready = 1'b0; stall_flag = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic send_ctrl(input string tag, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 32; n++) begin
      drive(1'b1, d, 1'b0, 1'b0);
      if (fifo_in_ready) begin ok = 1'b1; break; end
    end
    check_eq({tag, "_accept"}, 64'(ok), 64'd1);
  endtask

  task automatic start_test(input string tag, input logic [31:0] cmd, input logic [31:0] seed,
                            input logic [31:0] cnt);
    send_ctrl({tag, "_cmd"}, cmd);
    send_ctrl({tag, "_seed"}, seed);
    send_ctrl({tag, "_cnt"}, cnt);
  endtask

  task automatic recv_status(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2);
    logic [31:0] exp_w [3];
    logic [31:0] w;
    exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2;
    for (int k = 0; k < 3; k++) begin
      w = 32'hFFFF_FFFF;
      for (int n = 0; n < 64; n++) begin
        drive(1'b0, '0, 1'b1, 1'b0);
        if (fifo_out_valid) begin w = fifo_out_data; break; end
      end
      check_eq($sformatf("%s_status%0d", tag, k), 64'(w), 64'(exp_w[k]));
    end
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Host side of a write test; counts accepted words and stall-rule violations.
  task automatic write_stream(input logic [31:0] seed, input int n, input int bad0,
                              input int bad1, input bit stalls, output int sent,
                              output int viol);
    logic [31:0] s, w;
    bit st, st_prev;
    s = (seed == 0) ? 32'd1 : seed;
    sent = 0; viol = 0; st_prev = 1'b0;
    for (int cyc = 0; cyc < 40000 && sent < n; cyc++) begin
      st = stalls ? ($urandom_range(0, 3) == 0) : 1'b0;
      w  = lfsr_next(s);
      if (sent == bad0 || sent == bad1) w = w ^ 32'h0000_0100;
      drive(1'b1, w, 1'b0, st);
      if (fifo_in_ready) begin
        if (st_prev) viol++;
        s = lfsr_next(s);
        sent++;
      end
      st_prev = st;
    end
  endtask

  task automatic read_test(input string tag, input logic [31:0] reply, input bit exp_err);
    logic [31:0] s, first_w, held;
    int got, mism, hold_viol;
    bit pend;
    do_reset();
    start_test(tag, 32'h0000_5A01, 32'h0, 32'd64);
    s = 32'd1; got = 0; mism = 0; hold_viol = 0; pend = 1'b0; first_w = '1; held = '0;
    for (int cyc = 0; cyc < 10000 && got < 1024; cyc++) begin
      bit rdy;
      rdy = 1'($urandom_range(0, 1));
      drive(1'b0, '0, rdy, 1'b0);
      if (pend && fifo_out_valid && fifo_out_data != held) hold_viol++;
      pend = fifo_out_valid && !rdy;
      held = fifo_out_data;
      if (fifo_out_valid && rdy) begin
        if (got == 0) first_w = fifo_out_data;
        if (fifo_out_data != lfsr_next(s)) mism++;
        s = lfsr_next(s);
        got++;
      end
    end
    check_eq({tag, "_first"}, 64'(first_w), 64'h2);
    check_eq({tag, "_words"}, 64'(got), 64'd1024);
    check_eq({tag, "_mism"}, 64'(mism), 64'd0);
    check_eq({tag, "_hold"}, 64'(hold_viol), 64'd0);
    send_ctrl({tag, "_reply"}, reply);
    drive(1'b0, '0, 1'b0, 1'b0);
    check_eq({tag, "_error"}, 64'(error), 64'(exp_err));
    check_eq({tag, "_idle"}, 64'(idle), 64'd1);
  endtask

  initial begin
    int sent, viol, recv;
    logic [31:0] lb_words [16];
    logic [31:0] s;

    // Reset state
    do_reset();
    check_eq("rst_idle", 64'(idle), 64'd1);
    check_eq("rst_error", 64'(error), 64'd0);
    check_eq("rst_errcnt", 64'(err_count), 64'd0);
    check_eq("rst_outvalid", 64'(fifo_out_valid), 64'd0);
    check_eq("rst_inready", 64'(fifo_in_ready), 64'd1);

    // 1: clean write test, 1024 words
    start_test("wr", 32'h0000_5A00, 32'h0000_ACE1, 32'd64);
    write_stream(32'h0000_ACE1, 1024, -1, -1, 1'b0, sent, viol);
    check_eq("wr_sent", 64'(sent), 64'd1024);
    recv_status("wr", 32'hCAFE, 32'h0, 32'h0);
    check_eq("wr_error", 64'(error), 64'd0);
    check_eq("wr_idle", 64'(idle), 64'd1);

    // 2: words 5 and 700 corrupted
    do_reset();
    start_test("wrerr", 32'h0000_5A00, 32'h0000_ACE1, 32'd64);
    write_stream(32'h0000_ACE1, 1024, 5, 700, 1'b0, sent, viol);
    check_eq("wrerr_sent", 64'(sent), 64'd1024);
    recv_status("wrerr", 32'hDEAD, 32'h2, 32'h5);
    check_eq("wrerr_errcnt", 64'(err_count), 64'd2);
    check_eq("wrerr_error", 64'(error), 64'd1);

    // 3: read test with good and bad host replies
    read_test("rdok", 32'h0000_CAFE, 1'b0);
    read_test("rdbad", 32'h0000_1234, 1'b1);

    // 4: loopback, 16 words, random sink readiness
    do_reset();
    for (int i = 0; i < 16; i++) lb_words[i] = $urandom;
    start_test("lb", 32'h0000_5A02, 32'h0000_0001, 32'd1);
    sent = 0; recv = 0; viol = 0;
    for (int cyc = 0; cyc < 2000 && recv < 16; cyc++) begin
      bit rdy;
      rdy = 1'($urandom_range(0, 1));
      drive(sent < 16, (sent < 16) ? lb_words[sent] : 32'h0, rdy, 1'b0);
      if (fifo_in_ready && sent < 16) sent++;
      if (fifo_out_valid && rdy) begin
        if (fifo_out_data != lb_words[recv]) viol++;
        recv++;
      end
    end
    check_eq("lb_sent", 64'(sent), 64'd16);
    check_eq("lb_recv", 64'(recv), 64'd16);
    check_eq("lb_order", 64'(viol), 64'd0);
    recv_status("lb", 32'hCAFE, 32'h0, 32'h0);

    // 5: random waits plus external stall pulses
    do_reset();
    start_test("rw", 32'h0000_5A10, 32'h0000_ACE1, 32'd64);
    write_stream(32'h0000_ACE1, 1024, -1, -1, 1'b1, sent, viol);
    check_eq("rw_sent", 64'(sent), 64'd1024);
    check_eq("rw_stall_viol", 64'(viol), 64'd0);
    recv_status("rw", 32'hCAFE, 32'h0, 32'h0);
    check_eq("rw_error", 64'(error), 64'd0);

    // 6a: illegal mode, later commands ignored
    do_reset();
    send_ctrl("badcmd", 32'h0000_5A03);
    drive(1'b0, '0, 1'b0, 1'b0);
    check_eq("badcmd_error", 64'(error), 64'd1);
    check_eq("badcmd_idle", 64'(idle), 64'd1);
    drive(1'b1, 32'h0000_5A00, 1'b0, 1'b0);
    check_eq("badcmd_ignored", 64'(fifo_in_ready), 64'd0);
    repeat (3) drive(1'b1, 32'h0000_5A00, 1'b0, 1'b0);
    check_eq("badcmd_still_idle", 64'(idle), 64'd1);

    // 6b: zero count goes straight to status
    do_reset();
    start_test("cnt0", 32'h0000_5A00, 32'h0000_0005, 32'd0);
    recv_status("cnt0", 32'hCAFE, 32'h0, 32'h0);
    check_eq("cnt0_idle", 64'(idle), 64'd1);

    // 6c: reset in the middle of a run
    do_reset();
    start_test("midrst", 32'h0000_5A00, 32'h0000_0001, 32'd64);
    s = 32'd1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, lfsr_next(s), 1'b0, 1'b0);
      if (fifo_in_ready) s = lfsr_next(s);
    end
    check_eq("midrst_busy", 64'(idle), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    fifo_in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_idle", 64'(idle), 64'd1);
    check_eq("midrst_outvalid", 64'(fifo_out_valid), 64'd0);
    rst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
